// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one start/busy multiplier between two requesters.
// Each requester gets a mult-like port; products are routed back to the granted owner.
module mult_arbiter #(
  parameter int WIDTH  = 8,
  parameter int OWIDTH = 2 * WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [WIDTH-1:0]  req0_a_i,
  input  logic [WIDTH-1:0]  req0_b_i,
  input  logic              req0_start_i,
  output logic              req0_busy_o,
  output logic [OWIDTH-1:0] req0_y_bo,
  input  logic [WIDTH-1:0]  req1_a_i,
  input  logic [WIDTH-1:0]  req1_b_i,
  input  logic              req1_start_i,
  output logic              req1_busy_o,
  output logic [OWIDTH-1:0] req1_y_bo,
  output logic [WIDTH-1:0]  mul_a_o,
  output logic [WIDTH-1:0]  mul_b_o,
  output logic              mul_start_o,
  input  logic              mul_busy_i,
  input  logic [OWIDTH-1:0] mul_y_bi
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_e;

  logic [WIDTH-1:0] req_a [2];
  logic [WIDTH-1:0] req_b [2];
  logic [1:0]       req_start;

  assign req_a[0]  = req0_a_i;
  assign req_a[1]  = req1_a_i;
  assign req_b[0]  = req0_b_i;
  assign req_b[1]  = req1_b_i;
  assign req_start = {req1_start_i, req0_start_i};

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   grant, done;

  // A requester's busy flag doubles as its pending bit: set on capture, cleared on completion.
  logic [1:0]        busy_q, busy_d;
  logic              last_grant_q, last_grant_d;
  logic [WIDTH-1:0]  op_a_q [2];
  logic [WIDTH-1:0]  op_a_d [2];
  logic [WIDTH-1:0]  op_b_q [2];
  logic [WIDTH-1:0]  op_b_d [2];
  logic [OWIDTH-1:0] y_q [2];
  logic [OWIDTH-1:0] y_d [2];
  logic [WIDTH-1:0]  mul_a_q, mul_a_d;
  logic [WIDTH-1:0]  mul_b_q, mul_b_d;
  logic              mul_start_q, mul_start_d;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Next-state logic; a grant only happens once the mult has drained.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    grant   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!mul_busy_i && (busy_q != 2'b00)) begin
          grant   = 1'b1;
          owner_d = (busy_q == 2'b11) ? ~last_grant_q : busy_q[1];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE:     state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (mul_busy_i) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (!mul_busy_i) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    busy_d       = busy_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    y_d          = y_q;
    mul_start_d  = grant;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    if (grant) begin
      mul_a_d = op_a_q[owner_d];
      mul_b_d = op_b_q[owner_d];
    end
    if (done) last_grant_d = owner_q;
    for (int n = 0; n < 2; n++) begin
      // The owner is still busy at completion, so a capture can never collide with it.
      if (done && (owner_q == 1'(n))) begin
        busy_d[n] = 1'b0;
        y_d[n]    = mul_y_bi;
      end else if (req_start[n] && !busy_q[n]) begin
        busy_d[n] = 1'b1;
        op_a_d[n] = req_a[n];
        op_b_d[n] = req_b[n];
      end
    end
  end

  // NOTE: the operand and result registers are tiny and visible on ports, so they are reset too.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_q       <= 2'b00;
      last_grant_q <= 1'b1;
      op_a_q       <= '{default: '0};
      op_b_q       <= '{default: '0};
      y_q          <= '{default: '0};
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_start_q  <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      y_q          <= y_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_start_q  <= mul_start_d;
    end
  end

  assign req0_busy_o = busy_q[0];
  assign req1_busy_o = busy_q[1];
  assign req0_y_bo   = y_q[0];
  assign req1_y_bo   = y_q[1];
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;
  assign mul_start_o = mul_start_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed scenarios plus a random phase,
// all judged against a transaction-level model and a simple start/busy multiplier.
module tb_mult_arbiter;
  localparam int WIDTH  = 8;
  localparam int OWIDTH = 2 * WIDTH;
  localparam int MAX_WAIT = 60;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [WIDTH-1:0]  r_a [2];
  logic [WIDTH-1:0]  r_b [2];
  logic [1:0]        r_start;
  logic              req0_busy_o, req1_busy_o;
  logic [OWIDTH-1:0] req0_y_bo, req1_y_bo;
  logic [WIDTH-1:0]  mul_a_o, mul_b_o;
  logic              mul_start_o, mul_busy_i;
  logic [OWIDTH-1:0] mul_y_bi;

  always #5 clk = ~clk;

  mult_arbiter #(.WIDTH(WIDTH), .OWIDTH(OWIDTH)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req0_a_i     (r_a[0]),
    .req0_b_i     (r_b[0]),
    .req0_start_i (r_start[0]),
    .req0_busy_o  (req0_busy_o),
    .req0_y_bo    (req0_y_bo),
    .req1_a_i     (r_a[1]),
    .req1_b_i     (r_b[1]),
    .req1_start_i (r_start[1]),
    .req1_busy_o  (req1_busy_o),
    .req1_y_bo    (req1_y_bo),
    .mul_a_o      (mul_a_o),
    .mul_b_o      (mul_b_o),
    .mul_start_o  (mul_start_o),
    .mul_busy_i   (mul_busy_i),
    .mul_y_bi     (mul_y_bi)
  );

  // Multiplier model: busy for mult_lat+1 cycles after a start, product valid when busy drops.
  logic              mb_busy = 1'b0;
  int                mb_cnt  = 0;
  logic [OWIDTH-1:0] mb_y    = '0;
  logic [OWIDTH-1:0] mb_p    = '0;
  int                mult_lat = 2;
  logic              ext_busy = 1'b0;

  assign mul_busy_i = mb_busy | ext_busy;
  assign mul_y_bi   = mb_y;

  always @(posedge clk) begin
    if (!mb_busy) begin
      if (mul_start_o) begin
        mb_busy <= 1'b1;
        mb_cnt  <= mult_lat;
        mb_p    <= OWIDTH'(mul_a_o) * OWIDTH'(mul_b_o);
      end
    end else if (mb_cnt == 0) begin
      mb_busy <= 1'b0;
      mb_y    <= mb_p;
    end else begin
      mb_cnt <= mb_cnt - 1;
    end
  end

  logic [1:0]        busy_o;
  logic [OWIDTH-1:0] y_o [2];
  assign busy_o = {req1_busy_o, req0_busy_o};
  assign y_o[0] = req0_y_bo;
  assign y_o[1] = req1_y_bo;

  // Reference model state: accepted-but-unfinished requests and their expected products.
  int         checks = 0;
  int         failures = 0;
  logic [1:0] m_busy = 2'b00;
  int         exp_y [2] = '{0, 0};
  int         wait_cyc [2] = '{0, 0};
  logic [1:0] prev_busy = 2'b00;
  logic       prev_start = 1'b0;
  int         start_cnt = 0;
  int         done_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at every falling edge: judges what happened at the preceding rising edge.
  task automatic monitor();
    logic match;
    if (!rst_n) begin
      m_busy     = 2'b00;
      prev_busy  = 2'b00;
      prev_start = 1'b0;
      wait_cyc   = '{0, 0};
      return;
    end
    for (int n = 0; n < 2; n++) begin
      if (r_start[n] && !m_busy[n]) begin
        m_busy[n] = 1'b1;
        exp_y[n]  = int'(r_a[n]) * int'(r_b[n]);
        check($sformatf("accept%0d_busy", n), busy_o[n], 1);
      end
    end
    for (int n = 0; n < 2; n++) begin
      if (prev_busy[n] && !busy_o[n]) begin
        check($sformatf("req%0d_y", n), y_o[n], exp_y[n]);
        check($sformatf("req%0d_wait_bound", n), (wait_cyc[n] <= MAX_WAIT), 1);
        done_q.push_back(n);
        m_busy[n] = 1'b0;
      end
      wait_cyc[n] = busy_o[n] ? wait_cyc[n] + 1 : 0;
    end
    if (mul_start_o) begin
      start_cnt++;
      match = (m_busy[0] && (int'(mul_a_o) * int'(mul_b_o) == exp_y[0])) ||
              (m_busy[1] && (int'(mul_a_o) * int'(mul_b_o) == exp_y[1]));
      check("start_width", prev_start, 0);
      check("start_mult_idle", mul_busy_i, 0);
      check("start_owner_operands", match, 1);
    end
    prev_start = mul_start_o;
    prev_busy  = busy_o;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    #1;
  endtask

  task automatic pulse(input logic [1:0] who, input int a0, input int b0, input int a1, input int b1);
    r_a[0] = WIDTH'(a0);
    r_b[0] = WIDTH'(b0);
    r_a[1] = WIDTH'(a1);
    r_b[1] = WIDTH'(b1);
    r_start = who;
    tick();
    r_start = 2'b00;
  endtask

  task automatic wait_idle(input int n);
    for (int i = 0; i < 300 && m_busy[n]; i++) tick();
    check($sformatf("req%0d_done_timeout", n), m_busy[n], 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_outputs_zero",
          {req0_busy_o, req1_busy_o, req0_y_bo, req1_y_bo, mul_a_o, mul_b_o, mul_start_o}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int s0;
    rst_n   = 1'b1;
    r_start = 2'b00;
    r_a     = '{default: '0};
    r_b     = '{default: '0};
    tick();
    do_reset();
    check("post_reset_outputs_zero",
          {req0_busy_o, req1_busy_o, req0_y_bo, req1_y_bo, mul_a_o, mul_b_o, mul_start_o}, 0);

    // Simultaneous pair right after reset: requester 0 wins the first contention.
    done_q.delete();
    pulse(2'b11, 7, 9, 4, 4);
    wait_idle(0);
    wait_idle(1);
    check("pair1_count", done_q.size(), 2);
    check("pair1_first", done_q[0], 0);
    check("pair1_second", done_q[1], 1);
    check("pair1_y0", req0_y_bo, 63);
    check("pair1_y1", req1_y_bo, 16);

    // After a lone requester-0 op, the next contention goes to requester 1.
    pulse(2'b01, 2, 8, 0, 0);
    wait_idle(0);
    done_q.delete();
    pulse(2'b11, 10, 11, 12, 13);
    wait_idle(0);
    wait_idle(1);
    check("pair2_count", done_q.size(), 2);
    check("pair2_first", done_q[0], 1);
    check("pair2_second", done_q[1], 0);

    // Uncontended latency: start captured, one IDLE cycle, then the mult start pulse.
    do_reset();
    s0 = start_cnt;
    pulse(2'b01, 3, 5, 0, 0);
    check("t1_no_start_yet", mul_start_o, 0);
    tick();
    check("t1_start", mul_start_o, 1);
    check("t1_mul_a", mul_a_o, 3);
    check("t1_mul_b", mul_b_o, 5);
    wait_idle(0);
    check("t1_y0", req0_y_bo, 15);
    check("t1_one_start", start_cnt - s0, 1);
    check("t1_req1_untouched", {req1_busy_o, req1_y_bo}, 0);

    // Full-scale operands.
    pulse(2'b10, 0, 0, 255, 255);
    wait_idle(1);
    check("t3_y1", req1_y_bo, 65025);

    // A restart while busy is ignored.
    mult_lat = 6;
    pulse(2'b01, 5, 6, 0, 0);
    tick();
    pulse(2'b01, 9, 9, 0, 0);
    check("t4_still_busy", req0_busy_o, 1);
    wait_idle(0);
    check("t4_y0", req0_y_bo, 30);

    // Requester 0 restarts as soon as it is free: the waiting requester 1 goes first.
    done_q.delete();
    pulse(2'b01, 2, 3, 0, 0);
    tick();
    pulse(2'b10, 0, 0, 3, 3);
    for (int i = 0; i < 100 && req0_busy_o; i++) tick();
    pulse(2'b01, 4, 4, 0, 0);
    wait_idle(0);
    wait_idle(1);
    check("t5_count", done_q.size(), 3);
    check("t5_first", done_q[0], 0);
    check("t5_second", done_q[1], 1);
    check("t5_third", done_q[2], 0);
    check("t5_y0", req0_y_bo, 16);
    check("t5_y1", req1_y_bo, 9);

    // Reset mid-operation while the mult stays busy: no result, no start until drained.
    mult_lat = 10;
    pulse(2'b01, 2, 2, 0, 0);
    for (int i = 0; i < 20 && !mul_busy_i; i++) tick();
    tick();
    tick();
    ext_busy = 1'b1;
    do_reset();
    check("t6_y0_aborted", req0_y_bo, 0);
    pulse(2'b01, 6, 7, 0, 0);
    s0 = start_cnt;
    for (int i = 0; i < 12; i++) tick();
    check("t6_no_start_while_busy", start_cnt - s0, 0);
    check("t6_req0_waiting", req0_busy_o, 1);
    ext_busy = 1'b0;
    wait_idle(0);
    check("t6_y0", req0_y_bo, 42);
    check("t6_one_start", start_cnt - s0, 1);

    // Random traffic with random mult latency.
    for (int i = 0; i < 400; i++) begin
      mult_lat = $urandom_range(0, 4);
      for (int n = 0; n < 2; n++) begin
        r_a[n] = WIDTH'($urandom);
        r_b[n] = WIDTH'($urandom);
        r_start[n] = ($urandom_range(0, 3) == 0);
      end
      tick();
    end
    r_start = 2'b00;
    wait_idle(0);
    wait_idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
